npu_sram_burst_arbiter: RTL and testbench



---
 rtl/npu_sram_burst_arbiter_if.sv | 45 ++++
 rtl/npu_sram_burst_arbiter.sv | 120 ++++++++++++
 tb/tb_npu_sram_burst_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_sram_burst_arbiter_if.sv
// Bundle of requester-side handshakes and the shared SRAM port.
// The arbiter uses the slave modport; the environment (requesters plus SRAM)
// uses the master modport.
interface npu_sram_burst_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int LEN_W  = 8
);
  // Requester commands: bit/slice i belongs to requester i.
  logic [1:0]          cmd_valid;
  logic [1:0]          cmd_ready;
  logic [1:0]          cmd_write;
  logic [2*ADDR_W-1:0] cmd_addr;
  logic [2*LEN_W-1:0]  cmd_len;
  // Write data stream.
  logic [1:0]          wr_valid;
  logic [1:0]          wr_ready;
  logic [2*DATA_W-1:0] wr_data;
  logic [2*BE_W-1:0]   wr_be;
  // Read return, data shared and qualified per requester by rd_valid.
  logic [1:0]          rd_valid;
  logic [DATA_W-1:0]   rd_data;
  // SRAM port.
  logic [ADDR_W-1:0]   sram_address;
  logic [BE_W-1:0]     sram_byteenable;
  logic                sram_chipselect;
  logic                sram_write;
  logic [DATA_W-1:0]   sram_writedata;
  logic [DATA_W-1:0]   sram_readdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, wr_be,
           sram_readdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, sram_address,
           sram_byteenable, sram_chipselect, sram_write, sram_writedata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, wr_be,
           sram_readdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, sram_address,
           sram_byteenable, sram_chipselect, sram_write, sram_writedata
  );
endinterface

// File: rtl/npu_sram_burst_arbiter.sv
// Round-robin burst arbiter sharing one SRAM port between two NPU requesters.
// Handshakes: cmd_ready[i] pulses in the cycle a command of requester i is
// taken (valid held by the requester until then); a write word transfers in a
// cycle where wr_valid[g] and wr_ready[g] are both high; rd_valid[g] marks the
// cycle rd_data carries a read word, one cycle after the SRAM read is issued.
module npu_sram_burst_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  npu_sram_burst_arbiter_if.slave bus,
  output logic                    busy,
  output logic                    state_dbg
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic              gnt;         // requester owning the current burst
  logic              last_grant;  // requester served most recently
  logic              wr_flag;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  count;       // words left after the current one
  logic [1:0]        rd_pend;     // read issued last cycle, per requester

  logic              sel;
  logic              accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              cur_wr_valid;
  logic [DATA_W-1:0] cur_wr_data;
  logic [BE_W-1:0]   cur_wr_be;
  logic              issue;

  // Choose the requester to serve next; a tie goes to the one not served last.
  always_comb begin
    sel = bus.cmd_valid[1];
    if (&bus.cmd_valid) sel = ~last_grant;
    accept    = !reset && (state == IDLE) && (|bus.cmd_valid);
    sel_write = sel ? bus.cmd_write[1] : bus.cmd_write[0];
    sel_addr  = sel ? bus.cmd_addr[2*ADDR_W-1:ADDR_W] : bus.cmd_addr[ADDR_W-1:0];
    sel_len   = sel ? bus.cmd_len[2*LEN_W-1:LEN_W] : bus.cmd_len[LEN_W-1:0];
  end

  // Drive handshakes and the SRAM port from the current burst context.
  always_comb begin
    cur_wr_valid = gnt ? bus.wr_valid[1] : bus.wr_valid[0];
    cur_wr_data  = gnt ? bus.wr_data[2*DATA_W-1:DATA_W] : bus.wr_data[DATA_W-1:0];
    cur_wr_be    = gnt ? bus.wr_be[2*BE_W-1:BE_W] : bus.wr_be[BE_W-1:0];
    // A write word can only go out when its data is present; reads never stall.
    issue = !reset && (state == RUN) && (!wr_flag || cur_wr_valid);

    bus.cmd_ready = 2'b00;
    if (accept) bus.cmd_ready[sel] = 1'b1;

    bus.wr_ready = 2'b00;
    if (!reset && (state == RUN) && wr_flag) bus.wr_ready[gnt] = cur_wr_valid;

    bus.sram_chipselect = 1'b0;
    bus.sram_write      = 1'b0;
    bus.sram_address    = '0;
    bus.sram_byteenable = '0;
    bus.sram_writedata  = '0;
    if (issue) begin
      bus.sram_chipselect = 1'b1;
      bus.sram_address    = addr;
      if (wr_flag) begin
        bus.sram_write      = 1'b1;
        bus.sram_writedata  = cur_wr_data;
        bus.sram_byteenable = cur_wr_be;
      end else begin
        bus.sram_byteenable = '1;
      end
    end

    bus.rd_valid = rd_pend;
    bus.rd_data  = (|rd_pend) ? bus.sram_readdata : '0;
    busy         = (state == RUN) || (|rd_pend);
    state_dbg    = (state == RUN);
  end

  // Burst FSM: latch a granted command, then walk addresses until count hits 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      wr_flag    <= 1'b0;
      addr       <= '0;
      count      <= '0;
      rd_pend    <= 2'b00;
    end else begin
      rd_pend <= 2'b00;
      if (issue && !wr_flag) rd_pend[gnt] <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            gnt        <= sel;
            last_grant <= sel;
            wr_flag    <= sel_write;
            addr       <= sel_addr;
            count      <= sel_len;
            state      <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            addr  <= addr + ADDR_W'(1);
            count <= count - LEN_W'(1);
            if (count == '0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_sram_burst_arbiter.sv
// Bench for npu_sram_burst_arbiter: SRAM behavioural model, per-scenario test
// tasks, and a transaction-level model of expected memory and read data.
module tb_npu_sram_burst_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;
  localparam int LEN_W  = 8;

  typedef struct { int cyc; logic [14:0] addr; logic wr; logic [15:0] data; logic [1:0] be; } iss_t;
  typedef struct { int cyc; logic [1:0] vec; logic [15:0] data; } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic state_dbg;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_bad = 0;

  npu_sram_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LEN_W(LEN_W)) bus ();

  npu_sram_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    if (i >= 'h100 && i <= 'h103) return 16'(16'h00A0 + i - 'h100);
    return 16'((i * 40503) ^ 'h5A5A);
  endfunction

  // SRAM behavioural model: one-cycle read latency, byte-masked writes.
  logic [15:0] mem [0:32767];
  bit          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32768; i++) mem[i] = init_val(i);
      init_done = 1'b1;
    end else if (bus.sram_chipselect) begin
      if (bus.sram_write) begin
        if (bus.sram_byteenable[0]) mem[bus.sram_address][7:0]  = bus.sram_writedata[7:0];
        if (bus.sram_byteenable[1]) mem[bus.sram_address][15:8] = bus.sram_writedata[15:8];
      end else begin
        bus.sram_readdata <= mem[bus.sram_address];
      end
    end
  end

  // Monitor: logs SRAM accesses, read returns and grants outside reset.
  iss_t iss_log[$];
  ev_t  rdv_log[$];
  ev_t  grt_log[$];
  always begin
    iss_t e;
    ev_t  v;
    @(negedge clk);
    #2;
    if (!reset) begin
      if (bus.sram_chipselect) begin
        e.cyc = cyc; e.addr = bus.sram_address; e.wr = bus.sram_write;
        e.data = bus.sram_writedata; e.be = bus.sram_byteenable;
        iss_log.push_back(e);
      end
      if (bus.rd_valid != 2'b00) begin
        v.cyc = cyc; v.vec = bus.rd_valid; v.data = bus.rd_data;
        rdv_log.push_back(v);
      end
      if (bus.cmd_ready != 2'b00) begin
        v.cyc = cyc; v.vec = bus.cmd_ready; v.data = '0;
        grt_log.push_back(v);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] exp_mem [0:32767];
  logic [15:0] exp_q[$];
  logic [14:0] exp_a[$];
  bit          m_last;
  logic [15:0] bw_data [0:255];
  logic [1:0]  bw_be   [0:255];

  // Expected effect of one burst: address walk mod 2^15, read data, memory merge.
  task automatic model_burst(input int r, input bit wr, input logic [14:0] a, input logic [7:0] len);
    exp_q.delete();
    exp_a.delete();
    for (int k = 0; k <= int'(len); k++) begin
      int idx;
      idx = (int'(a) + k) % 32768;
      exp_a.push_back(15'(idx));
      if (wr) begin
        if (bw_be[k][0]) exp_mem[idx][7:0]  = bw_data[k][7:0];
        if (bw_be[k][1]) exp_mem[idx][15:8] = bw_data[k][15:8];
      end else begin
        exp_q.push_back(exp_mem[idx]);
      end
    end
    m_last = (r == 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_burst(input int r, input bit wr, input logic [14:0] a, input logic [7:0] len,
                             input int stall_at, input int stall_n);
    int k = 0;
    int st = 0;
    int guard = 0;
    bit accepted = 1'b0;
    bus.cmd_write[r] = wr;
    bus.cmd_addr[r*ADDR_W +: ADDR_W] = a;
    bus.cmd_len[r*LEN_W +: LEN_W] = len;
    while (guard < 3000 && !(accepted && (!wr || k > int'(len)))) begin
      @(negedge clk);
      bus.cmd_valid[r] = !accepted;
      bus.wr_valid[r] = 1'b0;
      if (wr && k <= int'(len)) begin
        if (k == stall_at && st < stall_n) st++;
        else begin
          bus.wr_valid[r] = 1'b1;
          bus.wr_data[r*DATA_W +: DATA_W] = bw_data[k];
          bus.wr_be[r*BE_W +: BE_W] = bw_be[k];
        end
      end
      #1;
      if (bus.cmd_ready[r]) accepted = 1'b1;
      if (wr && bus.wr_ready[r]) k++;
      guard++;
    end
    n_checks++;
    if (guard >= 3000) begin
      n_bad++;
      $display("FAIL burst_timeout: req %0d burst not completed, words=%0d required=%0d", r, k, int'(len) + 1);
    end
    @(negedge clk);
    bus.cmd_valid[r] = 1'b0;
    bus.wr_valid[r] = 1'b0;
  endtask

  task automatic wait_idle(output int idle_cyc);
    int guard = 0;
    idle_cyc = -1;
    while (guard < 2000) begin
      @(negedge clk);
      #1;
      if (!busy) begin idle_cyc = cyc; break; end
      guard++;
    end
    n_checks++;
    if (idle_cyc < 0) begin
      n_bad++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", guard);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;
    #1;
    n_checks++; if (state_dbg !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %0b want 0", state_dbg); end
    n_checks++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (bus.cmd_ready !== 2'b00) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 00", bus.cmd_ready); end
    n_checks++; if (bus.wr_ready !== 2'b00) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 00", bus.wr_ready); end
    n_checks++; if (bus.rd_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 00", bus.rd_valid); end
    n_checks++; if (bus.sram_chipselect !== 1'b0) begin n_bad++; $display("FAIL reset_cs: got %b want 0", bus.sram_chipselect); end
    n_checks++; if (bus.sram_write !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus.sram_write); end
    n_checks++; if (bus.sram_address !== 15'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.sram_address); end
    n_checks++; if (bus.sram_byteenable !== 2'b00) begin n_bad++; $display("FAIL reset_be: got %b want 00", bus.sram_byteenable); end
  endtask

  task automatic test_contention();
    int gi = grt_log.size();
    int ri = rdv_log.size();
    int idle_c;
    int req;
    @(negedge clk);
    bus.cmd_write = 2'b00;
    bus.cmd_len = '0;
    bus.cmd_addr = {15'h0020, 15'h0010};
    bus.cmd_valid = 2'b11;
    repeat (11) @(negedge clk);
    @(negedge clk);
    bus.cmd_valid = 2'b00;
    wait_idle(idle_c);
    n_checks++;
    if (grt_log.size() - gi !== 6) begin n_bad++; $display("FAIL cont_grants: got %0d want 6", grt_log.size() - gi); end
    n_checks++;
    if (rdv_log.size() - ri !== 6) begin n_bad++; $display("FAIL cont_reads: got %0d want 6", rdv_log.size() - ri); end
    for (int j = 0; j < 6 && gi + j < grt_log.size() && ri + j < rdv_log.size(); j++) begin
      logic [15:0] want;
      req = m_last ? 0 : 1;
      m_last = (req == 1);
      want = exp_mem[req ? 'h20 : 'h10];
      n_checks++;
      if (grt_log[gi+j].vec !== 2'(1 << req)) begin n_bad++; $display("FAIL cont_order[%0d]: got %b want req %0d", j, grt_log[gi+j].vec, req); end
      n_checks++;
      if (grt_log[gi+j].cyc - grt_log[gi].cyc !== 2*j) begin n_bad++; $display("FAIL cont_spacing[%0d]: got %0d want %0d", j, grt_log[gi+j].cyc - grt_log[gi].cyc, 2*j); end
      n_checks++;
      if (rdv_log[ri+j].vec !== 2'(1 << req) || rdv_log[ri+j].data !== want) begin
        n_bad++; $display("FAIL cont_rdata[%0d]: got %b/%h want req %0d/%h", j, rdv_log[ri+j].vec, rdv_log[ri+j].data, req, want);
      end
    end
  endtask

  task automatic test_read();
    int gi = grt_log.size();
    int ii = iss_log.size();
    int ri = rdv_log.size();
    int idle_c;
    model_burst(0, 1'b0, 15'h0100, 8'd3);
    drive_burst(0, 1'b0, 15'h0100, 8'd3, 0, 0);
    wait_idle(idle_c);
    n_checks++;
    if (grt_log.size() - gi !== 1 || grt_log[gi].vec !== 2'b01) begin n_bad++; $display("FAIL read_grant: got %0d grants want one on req 0", grt_log.size() - gi); end
    n_checks++;
    if (iss_log.size() - ii !== 4 || rdv_log.size() - ri !== 4) begin
      n_bad++; $display("FAIL read_counts: got %0d issues %0d returns want 4/4", iss_log.size() - ii, rdv_log.size() - ri);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (iss_log[ii+k].addr !== 15'(16'h0100 + k) || iss_log[ii+k].wr !== 1'b0 || iss_log[ii+k].be !== 2'b11) begin
          n_bad++; $display("FAIL read_issue[%0d]: got %h/%b/%b want %h/0/11", k, iss_log[ii+k].addr, iss_log[ii+k].wr, iss_log[ii+k].be, 16'h0100 + k);
        end
        n_checks++;
        if (rdv_log[ri+k].data !== 16'(16'h00A0 + k) || rdv_log[ri+k].data !== exp_q[k] || rdv_log[ri+k].vec !== 2'b01 ||
            rdv_log[ri+k].cyc !== iss_log[ii+k].cyc + 1) begin
          n_bad++; $display("FAIL read_data[%0d]: got %h on %b at +%0d want %h on 01 at +1", k, rdv_log[ri+k].data, rdv_log[ri+k].vec,
                            rdv_log[ri+k].cyc - iss_log[ii+k].cyc, exp_q[k]);
        end
      end
      n_checks++;
      if (idle_c !== rdv_log[ri+3].cyc + 1) begin n_bad++; $display("FAIL read_busy_drop: got cycle %0d want %0d", idle_c, rdv_log[ri+3].cyc + 1); end
    end
  endtask

  task automatic test_write_stall();
    int ii = iss_log.size();
    int ri;
    int idle_c;
    logic [15:0] orig;
    bw_data[0] = 16'h1111; bw_be[0] = 2'b11;
    bw_data[1] = 16'h2222; bw_be[1] = 2'b01;
    bw_data[2] = 16'h3333; bw_be[2] = 2'b11;
    model_burst(1, 1'b1, 15'h0200, 8'd2);
    drive_burst(1, 1'b1, 15'h0200, 8'd2, 1, 3);
    wait_idle(idle_c);
    n_checks++;
    if (iss_log.size() - ii !== 3) begin
      n_bad++; $display("FAIL wr_count: got %0d writes want 3", iss_log.size() - ii);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (iss_log[ii+k].addr !== exp_a[k] || iss_log[ii+k].wr !== 1'b1 || iss_log[ii+k].data !== bw_data[k] || iss_log[ii+k].be !== bw_be[k]) begin
          n_bad++; $display("FAIL wr_issue[%0d]: got %h/%b/%h/%b want %h/1/%h/%b", k, iss_log[ii+k].addr, iss_log[ii+k].wr,
                            iss_log[ii+k].data, iss_log[ii+k].be, exp_a[k], bw_data[k], bw_be[k]);
        end
      end
      n_checks++;
      if (iss_log[ii+1].cyc - iss_log[ii].cyc !== 4) begin n_bad++; $display("FAIL wr_stall_gap: got %0d want 4", iss_log[ii+1].cyc - iss_log[ii].cyc); end
    end
    ri = rdv_log.size();
    model_burst(1, 1'b0, 15'h0200, 8'd2);
    drive_burst(1, 1'b0, 15'h0200, 8'd2, 0, 0);
    wait_idle(idle_c);
    orig = init_val('h201);
    n_checks++;
    if (rdv_log.size() - ri !== 3) begin
      n_bad++; $display("FAIL wr_readback_count: got %0d want 3", rdv_log.size() - ri);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (rdv_log[ri+k].data !== exp_q[k] || rdv_log[ri+k].vec !== 2'b10) begin
          n_bad++; $display("FAIL wr_readback[%0d]: got %h on %b want %h on 10", k, rdv_log[ri+k].data, rdv_log[ri+k].vec, exp_q[k]);
        end
      end
      n_checks++;
      if (rdv_log[ri+1].data !== {orig[15:8], 8'h22}) begin n_bad++; $display("FAIL wr_byte_mask: got %h want %h", rdv_log[ri+1].data, {orig[15:8], 8'h22}); end
    end
  endtask

  task automatic test_wrap();
    int ii = iss_log.size();
    int ri = rdv_log.size();
    int idle_c;
    logic [14:0] want_a [0:3];
    want_a[0] = 15'h7FFE; want_a[1] = 15'h7FFF; want_a[2] = 15'h0000; want_a[3] = 15'h0001;
    model_burst(0, 1'b0, 15'h7FFE, 8'd3);
    drive_burst(0, 1'b0, 15'h7FFE, 8'd3, 0, 0);
    wait_idle(idle_c);
    n_checks++;
    if (iss_log.size() - ii !== 4 || rdv_log.size() - ri !== 4) begin
      n_bad++; $display("FAIL wrap_counts: got %0d/%0d want 4/4", iss_log.size() - ii, rdv_log.size() - ri);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (iss_log[ii+k].addr !== want_a[k]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, iss_log[ii+k].addr, want_a[k]); end
        n_checks++;
        if (rdv_log[ri+k].data !== exp_q[k]) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h want %h", k, rdv_log[ri+k].data, exp_q[k]); end
      end
    end
  endtask

  task automatic test_single();
    int ii = iss_log.size();
    int ri = rdv_log.size();
    int idle_c;
    bw_data[0] = 16'hBEEF; bw_be[0] = 2'b11;
    model_burst(0, 1'b1, 15'h0345, 8'd0);
    drive_burst(0, 1'b1, 15'h0345, 8'd0, 0, 0);
    wait_idle(idle_c);
    n_checks++;
    if (iss_log.size() - ii !== 1) begin n_bad++; $display("FAIL single_wr_count: got %0d want 1", iss_log.size() - ii); end
    ii = iss_log.size();
    model_burst(1, 1'b0, 15'h0345, 8'd0);
    drive_burst(1, 1'b0, 15'h0345, 8'd0, 0, 0);
    wait_idle(idle_c);
    n_checks++;
    if (iss_log.size() - ii !== 1) begin n_bad++; $display("FAIL single_rd_count: got %0d want 1", iss_log.size() - ii); end
    n_checks++;
    if (rdv_log.size() - ri !== 1) begin
      n_bad++; $display("FAIL single_rd_valid: got %0d cycles want 1", rdv_log.size() - ri);
    end else begin
      n_checks++;
      if (rdv_log[ri].data !== 16'hBEEF || rdv_log[ri].vec !== 2'b10) begin
        n_bad++; $display("FAIL single_rd_data: got %h on %b want beef on 10", rdv_log[ri].data, rdv_log[ri].vec);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      int r, gi, ii, ri, idle_c, stall_at, stall_n, n;
      bit wr;
      logic [14:0] a;
      logic [7:0] len;
      r = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 15'(32768 - $urandom_range(1, 4)) : 15'($urandom_range(0, 32767));
      len = 8'($urandom_range(0, 9));
      stall_at = $urandom_range(0, int'(len));
      stall_n = $urandom_range(0, 3);
      for (int k = 0; k <= int'(len); k++) begin
        bw_data[k] = 16'($urandom);
        bw_be[k] = 2'($urandom_range(0, 3));
      end
      gi = grt_log.size(); ii = iss_log.size(); ri = rdv_log.size();
      model_burst(r, wr, a, len);
      drive_burst(r, wr, a, len, stall_at, stall_n);
      wait_idle(idle_c);
      n = int'(len) + 1;
      n_checks++;
      if (grt_log.size() - gi !== 1 || grt_log[gi].vec !== 2'(1 << r)) begin
        n_bad++; $display("FAIL rnd_grant[%0d]: got %0d grants want one on req %0d", t, grt_log.size() - gi, r);
      end
      n_checks++;
      if (iss_log.size() - ii !== n || rdv_log.size() - ri !== (wr ? 0 : n)) begin
        n_bad++; $display("FAIL rnd_counts[%0d]: got %0d/%0d want %0d/%0d", t, iss_log.size() - ii, rdv_log.size() - ri, n, wr ? 0 : n);
      end else begin
        for (int k = 0; k < n; k++) begin
          n_checks++;
          if (iss_log[ii+k].addr !== exp_a[k] || iss_log[ii+k].wr !== wr ||
              (wr && (iss_log[ii+k].data !== bw_data[k] || iss_log[ii+k].be !== bw_be[k])) || (!wr && iss_log[ii+k].be !== 2'b11)) begin
            n_bad++; $display("FAIL rnd_issue[%0d.%0d]: got %h/%b/%h/%b want %h/%b", t, k, iss_log[ii+k].addr, iss_log[ii+k].wr,
                              iss_log[ii+k].data, iss_log[ii+k].be, exp_a[k], wr);
          end
          if (!wr) begin
            n_checks++;
            if (rdv_log[ri+k].data !== exp_q[k] || rdv_log[ri+k].vec !== 2'(1 << r) || rdv_log[ri+k].cyc !== iss_log[ii+k].cyc + 1) begin
              n_bad++; $display("FAIL rnd_rdata[%0d.%0d]: got %h on %b want %h on req %0d", t, k, rdv_log[ri+k].data, rdv_log[ri+k].vec, exp_q[k], r);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_midburst();
    int ii;
    int gi;
    int guard = 0;
    int idle_c;
    @(negedge clk);
    bus.cmd_write[0] = 1'b0;
    bus.cmd_addr[ADDR_W-1:0] = 15'h0400;
    bus.cmd_len[LEN_W-1:0] = 8'd7;
    bus.cmd_valid = 2'b01;
    #1;
    n_checks++;
    if (bus.cmd_ready !== 2'b01) begin n_bad++; $display("FAIL rst_accept: got %b want 01", bus.cmd_ready); end
    m_last = 1'b0;
    ii = iss_log.size();
    @(negedge clk);
    bus.cmd_valid = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;
    #1;
    n_checks++; if (bus.sram_chipselect !== 1'b0) begin n_bad++; $display("FAIL rst_cs: got %b want 0", bus.sram_chipselect); end
    n_checks++; if (bus.rd_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rd_valid: got %b want 00", bus.rd_valid); end
    n_checks++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (state_dbg !== 1'b0) begin n_bad++; $display("FAIL rst_state: got %b want 0", state_dbg); end
    n_checks++; if (iss_log.size() - ii !== 1) begin n_bad++; $display("FAIL rst_issues: got %0d want 1", iss_log.size() - ii); end
    gi = grt_log.size();
    bus.cmd_addr = {15'h0020, 15'h0010};
    bus.cmd_len = '0;
    bus.cmd_write = 2'b00;
    bus.cmd_valid = 2'b11;
    while (guard < 20 && grt_log.size() == gi) begin @(negedge clk); guard++; end
    bus.cmd_valid = 2'b00;
    wait_idle(idle_c);
    n_checks++;
    if (grt_log.size() == gi || grt_log[gi].vec !== (m_last ? 2'b01 : 2'b10)) begin
      n_bad++; $display("FAIL rst_tie: got %b want %b", (grt_log.size() == gi) ? 2'b00 : grt_log[gi].vec, m_last ? 2'b01 : 2'b10);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 2'b00; bus.cmd_write = 2'b00; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 2'b00; bus.wr_data = '0; bus.wr_be = '0;
    reset = 1'b1;
    for (int i = 0; i < 32768; i++) exp_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    test_reset();
    test_contention();
    test_read();
    test_write_stall();
    test_wrap();
    test_single();
    test_random();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
